// File: rtl/hex_display_pkg.sv
// Shared types and the hex-to-7-segment table for the hex display controller.
// Patterns are gfedcba, active-low (a 0 bit lights the segment).
package hex_display_pkg;

  typedef enum logic [1:0] {
    DISP_STATIC = 2'b00,
    DISP_BLINK  = 2'b01,
    DISP_SCROLL = 2'b10,
    DISP_BLANK  = 2'b11
  } disp_mode_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_encode.sv
// One-digit combinational encoder: nibble plus blank request to a 7-bit segment
// pattern in the polarity the board wants.
module seg7_hex_encode
  import hex_display_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] seg_al;

  assign seg_al = blank ? SEG_BLANK : hex_to_seg(nibble);
  assign seg    = (ACTIVE_LOW != 0) ? seg_al : ~seg_al;

endmodule

// File: rtl/hex_display_ctrl.sv
// N-digit hex 7-segment controller: nibble buffer, static/blink/scroll/blank modes,
// leading-zero suppression, fully registered segment outputs.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int BUF_NIBBLES = 16,
  parameter int BLINK_DIV   = 25_000_000,
  parameter int SCROLL_DIV  = 12_500_000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               load,
  input  logic [4*BUF_NIBBLES-1:0]           load_data,
  input  logic [$clog2(BUF_NIBBLES+1)-1:0]   load_len,
  input  logic [1:0]                         mode,
  input  logic                               lz_suppress,
  output logic [7*NUM_DIGITS-1:0]            seg_out,
  output logic                               scroll_done
);

  localparam int LEN_W    = $clog2(BUF_NIBBLES + 1);
  localparam int IDX_W    = $clog2(BUF_NIBBLES);
  localparam int BLINK_W  = $clog2(BLINK_DIV);
  localparam int SCROLL_W = $clog2(SCROLL_DIV);
  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;

  logic [4*BUF_NIBBLES-1:0] buf_q;
  logic [LEN_W-1:0]         len_q, len_in, offset_q;
  disp_mode_t               mode_q, mode_d;
  logic                     lz_q, blink_on_q, scroll_done_q;
  logic [BLINK_W-1:0]       blink_cnt_q;
  logic [SCROLL_W-1:0]      scroll_cnt_q;
  logic [7*NUM_DIGITS-1:0]  seg_q, seg_d;

  logic restart, blink_tick, scroll_tick, scroll_active, scroll_wrap;

  assign mode_d  = disp_mode_t'(mode);
  assign restart = load || (mode_d != mode_q);
  assign len_in  = (load_len > LEN_W'(BUF_NIBBLES)) ? LEN_W'(BUF_NIBBLES) : load_len;

  assign blink_tick    = (mode_q == DISP_BLINK)  && (blink_cnt_q  == BLINK_W'(BLINK_DIV - 1));
  assign scroll_tick   = (mode_q == DISP_SCROLL) && (scroll_cnt_q == SCROLL_W'(SCROLL_DIV - 1));
  assign scroll_active = len_q > LEN_W'(NUM_DIGITS);
  assign scroll_wrap   = scroll_tick && scroll_active && (offset_q == len_q - LEN_W'(1));

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (reset) begin
      buf_q         <= '0;
      len_q         <= '0;
      offset_q      <= '0;
      mode_q        <= DISP_STATIC;
      lz_q          <= 1'b0;
      blink_on_q    <= 1'b1;
      blink_cnt_q   <= '0;
      scroll_cnt_q  <= '0;
      scroll_done_q <= 1'b0;
      seg_q         <= {NUM_DIGITS{SEG_OFF}};
    end else begin
      mode_q        <= mode_d;
      lz_q          <= lz_suppress;
      seg_q         <= seg_d;
      scroll_done_q <= 1'b0;
      if (load) begin
        buf_q <= load_data;
        len_q <= len_in;
      end
      // New data or a new mode restarts the animation from a known point.
      if (restart) begin
        offset_q     <= '0;
        blink_on_q   <= 1'b1;
        blink_cnt_q  <= '0;
        scroll_cnt_q <= '0;
      end else begin
        if (mode_q == DISP_BLINK)
          blink_cnt_q <= blink_tick ? '0 : blink_cnt_q + BLINK_W'(1);
        if (blink_tick)
          blink_on_q <= ~blink_on_q;
        if (mode_q == DISP_SCROLL)
          scroll_cnt_q <= scroll_tick ? '0 : scroll_cnt_q + SCROLL_W'(1);
        if (scroll_tick && scroll_active) begin
          if (scroll_wrap) begin
            offset_q      <= '0;
            scroll_done_q <= 1'b1;
          end else begin
            offset_q <= offset_q + LEN_W'(1);
          end
        end
      end
    end
  end

  logic [3:0] buf_nib  [BUF_NIBBLES];
  logic [3:0] dig_nib  [NUM_DIGITS];
  logic       dig_blank[NUM_DIGITS];

  for (genvar k = 0; k < BUF_NIBBLES; k++) begin : g_unpack
    assign buf_nib[k] = buf_q[4*k +: 4];
  end

  always_comb begin
    int   idx;
    logic seen_nz;
    logic lz_blank;
    logic all_off;
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    dig_nib   = '{default: '0};
    dig_blank = '{default: 1'b1};
    idx       = 0;
    seen_nz   = 1'b0;
    lz_blank  = 1'b0;
    all_off   = (mode_q == DISP_BLANK) || ((mode_q == DISP_BLINK) && !blink_on_q);
    // Walk from the most significant digit so zero suppression stops at the first nonzero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      idx = i;
      if (mode_q == DISP_SCROLL) begin
        idx = int'(offset_q) + i;
        if (idx >= int'(len_q)) idx = idx - int'(len_q);
      end
      dig_nib[i] = buf_nib[IDX_W'(idx)];
      lz_blank   = 1'b0;
      if (i < int'(len_q)) begin
        if (lz_q && (mode_q != DISP_SCROLL) && !seen_nz && (dig_nib[i] == 4'h0) && (i != 0))
          lz_blank = 1'b1;
        else
          seen_nz = 1'b1;
      end
      dig_blank[i] = all_off || (i >= int'(len_q)) || lz_blank;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_hex_encode #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_enc (
      .nibble(dig_nib[g]),
      .blank (dig_blank[g]),
      .seg   (seg_d[7*g +: 7])
    );
  end

  assign seg_out     = seg_q;
  assign scroll_done = scroll_done_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with a 4-digit, 8-nibble configuration and
// short prescalers so blink and scroll cycles stay a few clocks long.
module tb_hex_display_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] load_data;
  logic [3:0]  load_len;
  logic [1:0]  mode;
  logic        lz_suppress;
  logic [27:0] seg_out;
  logic        scroll_done;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [27:0] ALL_OFF = 28'hFFFFFFF;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  hex_display_ctrl #(
    .NUM_DIGITS (4),
    .BUF_NIBBLES(8),
    .BLINK_DIV  (4),
    .SCROLL_DIV (3),
    .ACTIVE_LOW (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_data  (load_data),
    .load_len   (load_len),
    .mode       (mode),
    .lz_suppress(lz_suppress),
    .seg_out    (seg_out),
    .scroll_done(scroll_done)
  );

  always #5 clock = ~clock;

  function automatic logic [27:0] digits(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  // Expected digits 3..0 for buffer 0x76543210 (nibble n holds value n) at a scroll offset.
  function automatic logic [27:0] scroll_view(input int off, input int len);
    return {SEG_TAB[(off + 3) % len], SEG_TAB[(off + 2) % len],
            SEG_TAB[(off + 1) % len], SEG_TAB[off % len]};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'bx; load_data = 'x; load_len = 'x; mode = 'x; lz_suppress = 1'bx;
    step(); step();
    n_cmp++;
    if (seg_out !== ALL_OFF) begin
      n_bad++; $display("FAIL reset_seg: seg_out=%h expected %h", seg_out, ALL_OFF);
    end
    n_cmp++;
    if (scroll_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_done: scroll_done=%b expected 0", scroll_done);
    end
    reset = 1'b0; load = 1'b1; load_data = 32'h0000_1A3F; load_len = 4'd4; mode = 2'b00;
    lz_suppress = 1'b0;
    step();
    load = 1'b0;
    n_cmp++;
    if (seg_out !== ALL_OFF) begin
      n_bad++; $display("FAIL load_latency: seg_out=%h expected %h", seg_out, ALL_OFF);
    end
    step();
    n_cmp++;
    if (seg_out !== digits(7'h79, 7'h08, 7'h30, 7'h0E)) begin
      n_bad++; $display("FAIL static_1A3F: seg_out=%h expected %h", seg_out,
                        digits(7'h79, 7'h08, 7'h30, 7'h0E));
    end
  endtask

  task automatic test_lz_suppress();
    logic [31:0] data_v [4] = '{32'h0050, 32'h0000, 32'h0005, 32'h0050};
    logic [3:0]  len_v  [4] = '{4'd4, 4'd4, 4'd3, 4'd4};
    logic        lz_v   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [27:0] exp_v  [4];
    exp_v[0] = digits(7'h7F, 7'h7F, 7'h12, 7'h40);
    exp_v[1] = digits(7'h7F, 7'h7F, 7'h7F, 7'h40);
    exp_v[2] = digits(7'h7F, 7'h7F, 7'h7F, 7'h12);
    exp_v[3] = digits(7'h40, 7'h40, 7'h12, 7'h40);
    for (int v = 0; v < 4; v++) begin
      load = 1'b1; load_data = data_v[v]; load_len = len_v[v]; lz_suppress = lz_v[v];
      step();
      load = 1'b0;
      step();
      n_cmp++;
      if (seg_out !== exp_v[v]) begin
        n_bad++; $display("FAIL lz_case%0d: seg_out=%h expected %h", v, seg_out, exp_v[v]);
      end
    end
  endtask

  task automatic test_blink();
    logic [27:0] on_v;
    on_v = digits(7'h79, 7'h08, 7'h30, 7'h0E);
    mode = 2'b01; load = 1'b1; load_data = 32'h0000_1A3F; load_len = 4'd4; lz_suppress = 1'b0;
    step();
    load = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      n_cmp++;
      if (seg_out !== ((((j - 1) / 4) % 2 == 0) ? on_v : ALL_OFF)) begin
        n_bad++; $display("FAIL blink j=%0d: seg_out=%h expected %h", j, seg_out,
                          ((((j - 1) / 4) % 2 == 0) ? on_v : ALL_OFF));
      end
    end
    // Load during the off phase restarts the blink with the phase on.
    load = 1'b1;
    step();
    load = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step();
      n_cmp++;
      if (seg_out !== ((j <= 4) ? on_v : ALL_OFF)) begin
        n_bad++; $display("FAIL blink_reload j=%0d: seg_out=%h expected %h", j, seg_out,
                          ((j <= 4) ? on_v : ALL_OFF));
      end
    end
  endtask

  task automatic test_scroll();
    int done_cnt;
    done_cnt = 0;
    mode = 2'b10; load = 1'b1; load_data = 32'h7654_3210; load_len = 4'd6;
    step();
    load = 1'b0;
    for (int j = 1; j <= 36; j++) begin
      step();
      n_cmp++;
      if (seg_out !== scroll_view(((j - 1) / 3) % 6, 6)) begin
        n_bad++; $display("FAIL scroll j=%0d: seg_out=%h expected %h", j, seg_out,
                          scroll_view(((j - 1) / 3) % 6, 6));
      end
      n_cmp++;
      if (scroll_done !== ((j % 18) == 0)) begin
        n_bad++; $display("FAIL scroll_done j=%0d: got %b expected %b", j, scroll_done,
                          ((j % 18) == 0));
      end
      if (j == 4) begin
        n_cmp++;
        if (seg_out !== digits(7'h19, 7'h30, 7'h24, 7'h79)) begin
          n_bad++; $display("FAIL scroll_off1: seg_out=%h expected %h", seg_out,
                            digits(7'h19, 7'h30, 7'h24, 7'h79));
        end
      end
      if (j == 13) begin
        n_cmp++;
        if (seg_out !== digits(7'h79, 7'h40, 7'h12, 7'h19)) begin
          n_bad++; $display("FAIL scroll_off4: seg_out=%h expected %h", seg_out,
                            digits(7'h79, 7'h40, 7'h12, 7'h19));
        end
      end
      if (scroll_done === 1'b1) done_cnt++;
    end
    n_cmp++;
    if (done_cnt != 2) begin
      n_bad++; $display("FAIL scroll_done_count: got %0d expected 2", done_cnt);
    end
  endtask

  task automatic test_scroll_short();
    load = 1'b1; load_data = 32'h7654_3210; load_len = 4'd3;
    step();
    load = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      n_cmp++;
      if (seg_out !== digits(7'h7F, 7'h24, 7'h79, 7'h40) || scroll_done !== 1'b0) begin
        n_bad++; $display("FAIL scroll_len3 j=%0d: seg_out=%h done=%b expected %h done=0", j,
                          seg_out, scroll_done, digits(7'h7F, 7'h24, 7'h79, 7'h40));
      end
    end
    load = 1'b1; load_len = 4'd0;
    step();
    load = 1'b0;
    step();
    n_cmp++;
    if (seg_out !== ALL_OFF) begin
      n_bad++; $display("FAIL scroll_len0: seg_out=%h expected %h", seg_out, ALL_OFF);
    end
    // A length of 12 clamps to 8, so the scroll wraps after 8 offsets.
    load = 1'b1; load_len = 4'd12;
    step();
    load = 1'b0;
    for (int j = 1; j <= 24; j++) begin
      step();
      if (j == 1 || j == 22) begin
        n_cmp++;
        if (seg_out !== ((j == 1) ? digits(7'h30, 7'h24, 7'h79, 7'h40)
                                  : digits(7'h24, 7'h79, 7'h40, 7'h78))) begin
          n_bad++; $display("FAIL clamp_view j=%0d: seg_out=%h", j, seg_out);
        end
      end
      n_cmp++;
      if (scroll_done !== (j == 24)) begin
        n_bad++; $display("FAIL clamp_done j=%0d: got %b expected %b", j, scroll_done, (j == 24));
      end
    end
  endtask

  task automatic test_blank();
    mode = 2'b11;
    step(); step();
    n_cmp++;
    if (seg_out !== ALL_OFF) begin
      n_bad++; $display("FAIL blank_mode: seg_out=%h expected %h", seg_out, ALL_OFF);
    end
    mode = 2'b00;
    step(); step();
    n_cmp++;
    if (seg_out !== digits(7'h30, 7'h24, 7'h79, 7'h40)) begin
      n_bad++; $display("FAIL blank_retain: seg_out=%h expected %h", seg_out,
                        digits(7'h30, 7'h24, 7'h79, 7'h40));
    end
  endtask

  task automatic test_back_to_back();
    mode = 2'b10;
    for (int j = 0; j < 5; j++) step();
    // Reset wins over a simultaneous load.
    reset = 1'b1; load = 1'b1; load_data = 32'h0000_1A3F; load_len = 4'd4;
    step();
    n_cmp++;
    if (seg_out !== ALL_OFF || scroll_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid: seg_out=%h done=%b expected %h done=0", seg_out,
                        scroll_done, ALL_OFF);
    end
    reset = 1'b0; load = 1'b0; mode = 2'b00;
    step(); step();
    n_cmp++;
    if (seg_out !== ALL_OFF) begin
      n_bad++; $display("FAIL reset_beats_load: seg_out=%h expected %h", seg_out, ALL_OFF);
    end
    // Mode change and load in one cycle: both take effect, blink starts on.
    mode = 2'b01; load = 1'b1; load_data = 32'h0000_1A3F; load_len = 4'd4;
    step();
    load = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step();
      n_cmp++;
      if (seg_out !== ((j <= 4) ? digits(7'h79, 7'h08, 7'h30, 7'h0E) : ALL_OFF)) begin
        n_bad++; $display("FAIL mode_load_blink j=%0d: seg_out=%h", j, seg_out);
      end
    end
    // Into scroll from blink with a load: offset 0 and a fresh prescaler.
    mode = 2'b10; load = 1'b1; load_data = 32'h7654_3210; load_len = 4'd6;
    step();
    load = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      step();
      n_cmp++;
      if (seg_out !== ((j <= 3) ? digits(7'h30, 7'h24, 7'h79, 7'h40)
                                : digits(7'h19, 7'h30, 7'h24, 7'h79))) begin
        n_bad++; $display("FAIL mode_load_scroll j=%0d: seg_out=%h", j, seg_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lz_suppress();
    test_blink();
    test_scroll();
    test_scroll_short();
    test_blank();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
